alu_cmd_queue: RTL and testbench
================================

# alu_cmd_queue

Command buffer and issue stage directly upstream of the ALU. Accepts ALU commands (opcode, operand, power on/off requests) over a valid/ready handshake, holds them in a DEPTH-entry FIFO, and issues at most one per clock onto registered outputs that drive the ALU's `op`, `in`, `on` and `off` ports. The block also tracks a shadow copy of the ALU power state. When no command is available, it issues NOP.

## Interface
- `N`, 8: operand width; must equal the ALU `n`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock, shared with ALU.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  upstream command present.
- `cmd_ready`  out  1  queue can accept a command.
- `cmd_op`  in  4  opcode.
- `cmd_in`  in  N  operand.
- `cmd_on`, `cmd_off`  in  1 each  power requests travelling with the command.
- `hold`  in  1  stall issue; queue contents are kept.
- `flush`  in  1  synchronous discard of all queued commands.
- `alu_op`  out  4  registered; drives ALU `op`.
- `alu_in`  out  N  registered; drives ALU `in`.
- `alu_on`, `alu_off`  out  1 each  registered; drive ALU `on`/`off`.
- `alu_valid`  out  1  the `alu_*` outputs hold a dequeued command, not filler.
- `alu_pwr`  out  1  shadow of the ALU power state after the issued command.
- `count`  out  clog2(DEPTH)+1  current occupancy.
- `bad_op`  out  1  sticky illegal-opcode flag.

## Operation
- Opcode map: NOP 0000, LOAD 0001, NOT 0010, XOR 0011, OR 0100, AND 0101, SUB 0110, ADD 0111, MULT 1000.
- Push happens when `cmd_valid & cmd_ready`.
- `cmd_ready = !full & !flush`.
  - Depends only on `count` and `flush`; there is no combinational path from `cmd_valid`.
  - When full, no push is accepted, even on a cycle that pops.
- Illegal opcodes (1001–1111):
  - At push, the entry is stored as op 0000 with operand 0; `cmd_on`/`cmd_off` are kept.
  - `bad_op` is set and stays set until `rst`.
- Pop happens when `!empty & !hold & !flush`.
  - The head entry loads into the `alu_*` registers.
  - `alu_valid` goes to 1.
- No pop: the `alu_*` registers load op 0000, in 0, on 0, off 0, and `alu_valid` goes to 0.
  - The ALU therefore re-presents its previous result.
- Simultaneous push and pop when not full: both occur and `count` is unchanged.
- Push into an empty queue: the entry cannot be popped in the same cycle (no bypass).
- Flush: pointers and `count` clear to 0. Any push in the same cycle is dropped (`cmd_ready` is low). The next issue is NOP.
- Shadow power, updated on each pop:
  - `alu_on` set → 1 (on wins over off).
  - else `alu_off` set → 0.
  - else unchanged.
- Pointers wrap modulo DEPTH. `count` ranges 0..DEPTH.

## Timing
- Reset (`rst` low, asynchronous):
  - `alu_op`=0, `alu_in`=0, `alu_on`=0, `alu_off`=0, `alu_valid`=0.
  - `alu_pwr`=1, matching the ALU reset to ON.
  - `count`=0, `bad_op`=0, FIFO empty.
  - `cmd_ready`=1 once `flush` is low.
- Reset mid-operation discards queued and issuing commands immediately. Outputs take reset values without waiting for a clock edge.
- Release: the first edge after `rst` rises is a normal cycle.
- Latency: a command accepted at edge k appears on `alu_*` after edge k+1 at the earliest. The ALU result is registered at edge k+2.
- Throughput: one command per cycle when fed continuously.
- `hold` is sampled at the edge. A hold asserted for one cycle inserts exactly one NOP and loses no command.
- Power commands issue in FIFO order together with their opcode.
  - The shadow reflects the ALU's state from the edge following issue.
  - `alu_pwr` updates at the same edge as the `alu_*` registers.

## Test plan
- Reset, then push LOAD 8'h05, then ADD 8'h03 on consecutive cycles → `alu_op`/`alu_in` = 0001/05 then 0111/03 on the cycles after each accept. `alu_valid` is 1, 1, then 0 with NOP.
- With `hold`=1, push 4 commands (DEPTH 4) → `count`=4 and `cmd_ready`=0. A fifth push is not accepted. After `hold` is released, the commands issue in order over 4 cycles and `count` reaches 0.
- Full queue, `hold`=0, `cmd_valid`=1 continuously → `cmd_ready` stays 0 until `count`=3. Steady state then sustains one issue per cycle with `count` constant.
- Push op 1011 with operand 8'hFF → issued as 0000/00 and `bad_op`=1. `bad_op` stays 1 until `rst` is low.
- Push an entry with `off`=1, then one with `on`=1 and `off`=1 → `alu_pwr` is 0 after the first issue and 1 after the second.
- Queue 3 entries, assert `flush` with `cmd_valid`=1 → `count`=0, the push is dropped, and the next issue is NOP. Separately, assert `rst` low while `count`=2 → outputs go to reset values immediately.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// Command FIFO and issue stage in front of the ALU: buffers commands, issues one per
// clock onto registered ALU drive lines, and shadows the ALU power state.
module alu_cmd_queue #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [N-1:0]             cmd_in,
    input  logic                     cmd_on,
    input  logic                     cmd_off,
    input  logic                     hold,
    input  logic                     flush,
    output logic [3:0]               alu_op,
    output logic [N-1:0]             alu_in,
    output logic                     alu_on,
    output logic                     alu_off,
    output logic                     alu_valid,
    output logic                     alu_pwr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     bad_op
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [3:0]  OP_NOP   = 4'b0000;
    localparam logic [3:0]  OP_MULT  = 4'b1000;

    logic [3:0]    mem_op  [DEPTH];
    logic [N-1:0]  mem_in  [DEPTH];
    logic          mem_on  [DEPTH];
    logic          mem_off [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          illegal;

    // Readiness looks only at occupancy and flush, so a full queue refuses a push
    // even on a cycle where it also pops.
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = !empty && !hold && !flush;
    assign illegal   = (cmd_op > OP_MULT);

    // Illegal opcodes are neutralised to NOP/0 at entry; power requests survive.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr]  <= illegal ? OP_NOP : cmd_op;
            mem_in[wr_ptr]  <= illegal ? '0 : cmd_in;
            mem_on[wr_ptr]  <= cmd_on;
            mem_off[wr_ptr] <= cmd_off;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            bad_op    <= 1'b0;
            alu_op    <= OP_NOP;
            alu_in    <= '0;
            alu_on    <= 1'b0;
            alu_off   <= 1'b0;
            alu_valid <= 1'b0;
            alu_pwr   <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end

            if (push && illegal) bad_op <= 1'b1;

            // On wins over off when a command carries both power requests.
            if (pop) begin
                alu_op    <= mem_op[rd_ptr];
                alu_in    <= mem_in[rd_ptr];
                alu_on    <= mem_on[rd_ptr];
                alu_off   <= mem_off[rd_ptr];
                alu_valid <= 1'b1;
                if (mem_on[rd_ptr])       alu_pwr <= 1'b1;
                else if (mem_off[rd_ptr]) alu_pwr <= 1'b0;
            end else begin
                alu_op    <= OP_NOP;
                alu_in    <= '0;
                alu_on    <= 1'b0;
                alu_off   <= 1'b0;
                alu_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based reference model.
module tb_alu_cmd_queue;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [N-1:0]  cmd_in;
    logic          cmd_on;
    logic          cmd_off;
    logic          hold;
    logic          flush;
    logic [3:0]    alu_op;
    logic [N-1:0]  alu_in;
    logic          alu_on;
    logic          alu_off;
    logic          alu_valid;
    logic          alu_pwr;
    logic [$clog2(DEPTH):0] count;
    logic          bad_op;

    int checks   = 0;
    int failures = 0;

    alu_cmd_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_in(cmd_in), .cmd_on(cmd_on), .cmd_off(cmd_off),
        .hold(hold), .flush(flush),
        .alu_op(alu_op), .alu_in(alu_in), .alu_on(alu_on), .alu_off(alu_off),
        .alu_valid(alu_valid), .alu_pwr(alu_pwr), .count(count), .bad_op(bad_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a plain queue of sanitised commands plus the issue registers.
    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] in;
        logic         on;
        logic         off;
    } entry_t;

    entry_t        mq[$];
    logic [3:0]    m_op    = 4'd0;
    logic [N-1:0]  m_in    = '0;
    logic          m_on    = 1'b0;
    logic          m_off   = 1'b0;
    logic          m_valid = 1'b0;
    logic          m_pwr   = 1'b1;
    logic          m_bad   = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_op = 4'd0; m_in = '0; m_on = 1'b0; m_off = 1'b0;
            m_valid = 1'b0; m_pwr = 1'b1; m_bad = 1'b0;
        end else begin
            automatic bit     rdy   = (mq.size() < DEPTH) && !flush;
            automatic bit     do_pop = (mq.size() > 0) && !hold && !flush;
            automatic entry_t e;
            if (do_pop) begin
                e = mq.pop_front();
                m_op = e.op; m_in = e.in; m_on = e.on; m_off = e.off; m_valid = 1'b1;
                if (e.on) m_pwr = 1'b1;
                else if (e.off) m_pwr = 1'b0;
            end else begin
                m_op = 4'd0; m_in = '0; m_on = 1'b0; m_off = 1'b0; m_valid = 1'b0;
            end
            if (flush) mq.delete();
            if (cmd_valid && rdy) begin
                if (cmd_op > 4'd8) begin
                    e.op = 4'd0; e.in = '0; m_bad = 1'b1;
                end else begin
                    e.op = cmd_op; e.in = cmd_in;
                end
                e.on = cmd_on; e.off = cmd_off;
                mq.push_back(e);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every mid-cycle the DUT outputs must agree with the model.
    always @(negedge clk) begin
        checkOutput("m_alu_op",    alu_op,    m_op);
        checkOutput("m_alu_in",    alu_in,    m_in);
        checkOutput("m_alu_on",    alu_on,    m_on);
        checkOutput("m_alu_off",   alu_off,   m_off);
        checkOutput("m_alu_valid", alu_valid, m_valid);
        checkOutput("m_alu_pwr",   alu_pwr,   m_pwr);
        checkOutput("m_bad_op",    bad_op,    m_bad);
        checkOutput("m_count",     count,     mq.size());
        checkOutput("m_cmd_ready", cmd_ready, (mq.size() < DEPTH) && !flush);
    end

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [N-1:0] din,
                                 input logic on, input logic off, input logic h, input logic f);
        cmd_valid = v; cmd_op = op; cmd_in = din; cmd_on = on; cmd_off = off;
        hold = h; flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        tick(); tick();
        checkOutput("rst_pwr",   alu_pwr,   1);
        checkOutput("rst_count", count,     0);
        checkOutput("rst_ready", cmd_ready, 1);
        checkOutput("rst_valid", alu_valid, 0);
        rst = 1'b1;
        tick();

        // LOAD 05 then ADD 03 back to back
        applyStimulus(1, 4'b0001, 8'h05, 0, 0, 0, 0); tick();
        applyStimulus(1, 4'b0111, 8'h03, 0, 0, 0, 0); tick();
        checkOutput("t1_op0", alu_op, 4'b0001);
        checkOutput("t1_in0", alu_in, 8'h05);
        checkOutput("t1_v0",  alu_valid, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("t1_op1", alu_op, 4'b0111);
        checkOutput("t1_in1", alu_in, 8'h03);
        checkOutput("t1_v1",  alu_valid, 1);
        tick();
        checkOutput("t1_v2",  alu_valid, 0);
        checkOutput("t1_op2", alu_op, 4'b0000);

        // Fill under hold, refuse a fifth, then drain in order
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 4'(i), 8'(i * 8'h11), 0, 0, 1, 0); tick();
        end
        checkOutput("t2_count4", count, 4);
        checkOutput("t2_ready0", cmd_ready, 0);
        applyStimulus(1, 4'b0101, 8'h99, 0, 0, 1, 0); tick();
        checkOutput("t2_count_still4", count, 4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput("t2_op",    alu_op, 4'(i));
            checkOutput("t2_in",    alu_in, 8'(i * 8'h11));
            checkOutput("t2_count", count,  4 - i);
        end
        tick();

        // Full queue with continuous valid settles to count 3, one issue per cycle
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 4'b0100, 8'h20, 0, 0, 1, 0); tick();
        end
        applyStimulus(1, 4'b0101, 8'h55, 0, 0, 0, 0);
        checkOutput("t3_ready_full", cmd_ready, 0);
        tick();
        checkOutput("t3_count3", count, 3);
        checkOutput("t3_ready1", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t3_steady_count", count, 3);
            checkOutput("t3_steady_valid", alu_valid, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (5) tick();

        // Illegal opcode is neutralised and flagged
        applyStimulus(1, 4'b1011, 8'hFF, 0, 0, 0, 0); tick();
        checkOutput("t4_bad", bad_op, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("t4_op",    alu_op, 0);
        checkOutput("t4_in",    alu_in, 0);
        checkOutput("t4_valid", alu_valid, 1);

        // Power shadow: off, then on+off
        applyStimulus(1, 4'b0001, 8'h00, 0, 1, 0, 0); tick();
        applyStimulus(1, 4'b0001, 8'h00, 1, 1, 0, 0); tick();
        checkOutput("t5_pwr_off", alu_pwr, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("t5_pwr_on", alu_pwr, 1);
        checkOutput("t4_bad_sticky", bad_op, 1);
        tick();

        // Flush drops queued entries and the concurrent push
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4'b0011, 8'h0F, 0, 0, 1, 0); tick();
        end
        checkOutput("t6_count3", count, 3);
        applyStimulus(1, 4'b0010, 8'hAA, 0, 0, 0, 1);
        #1;
        checkOutput("t6_ready_flush", cmd_ready, 0);
        tick();
        checkOutput("t6_count0", count, 0);
        checkOutput("t6_nop",    alu_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("t6_after",  alu_valid, 0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4'b0110, 8'h42, 0, 1, 1, 0); tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("t7_count2", count, 2);
        checkOutput("t7_valid1", alu_valid, 1);
        hold = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("t7_rst_count", count, 0);
        checkOutput("t7_rst_valid", alu_valid, 0);
        checkOutput("t7_rst_op",    alu_op, 0);
        checkOutput("t7_rst_pwr",   alu_pwr, 1);
        checkOutput("t7_rst_bad",   bad_op, 0);
        checkOutput("t7_rst_ready", cmd_ready, 1);
        tick();
        rst = 1'b1;
        hold = 1'b0;
        tick();

        // Random traffic, the negedge comparator does the checking
        for (int cyc = 0; cyc < 3000; cyc++) begin
            automatic int mode = (cyc / 300) % 3;
            applyStimulus(($urandom_range(0, 9) < (mode == 0 ? 9 : 5)),
                          4'($urandom_range(0, 9) == 0 ? $urandom_range(9, 15) : $urandom_range(0, 8)),
                          8'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                          (mode == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b0;
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
